// File: rtl/dvp_pkg.sv
// dvp_pkg: capture state encoding, RGB565 colour-bar constants and default panel geometry.
package dvp_pkg;
    typedef enum logic [1:0] {S_SYNC, S_SKIP, S_FRAME, S_DROP} state_e;
    localparam int H_ACTIVE_DEF = 480;
    localparam int V_ACTIVE_DEF = 272;
    localparam logic [15:0] C_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_CYAN    = 16'h07FF;
    localparam logic [15:0] C_GREEN   = 16'h07E0;
    localparam logic [15:0] C_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_RED     = 16'hF800;
    localparam logic [15:0] C_BLUE    = 16'h001F;
    localparam logic [15:0] C_BLACK   = 16'h0000;
    function automatic logic [15:0] bar_color(input logic [2:0] i);
        case (i)
            3'd0: return C_WHITE;
            3'd1: return C_YELLOW;
            3'd2: return C_CYAN;
            3'd3: return C_GREEN;
            3'd4: return C_MAGENTA;
            3'd5: return C_RED;
            3'd6: return C_BLUE;
            default: return C_BLACK;
        endcase
    endfunction
endpackage

// File: rtl/dvp_capture_if.sv
// dvp_capture_if: camera DVP bus plus display-FIFO write port seen by the capture block.
interface dvp_capture_if;
    logic        CSI_HREF;
    logic        CSI_VSYNC;
    logic [7:0]  CSI_D;
    logic        FIFO_FULL;
    logic        FIFO_WE;
    logic [15:0] FIFO_DI;
    modport master (output CSI_HREF, CSI_VSYNC, CSI_D, FIFO_FULL, input FIFO_WE, FIFO_DI);
    modport slave (input CSI_HREF, CSI_VSYNC, CSI_D, FIFO_FULL, output FIFO_WE, FIFO_DI);
endinterface

// File: rtl/dvp_sync_edge.sv
// dvp_sync_edge: registers the DVP pins once, normalises polarity and flags HREF fall / VSYNC rise.
module dvp_sync_edge #(
    parameter bit VSYNC_POL = 1'b1,
    parameter bit HREF_POL  = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       href_i,
    input  logic       vsync_i,
    input  logic [7:0] d_i,
    output logic       href_o,
    output logic       href_fall_o,
    output logic       vsync_rise_o,
    output logic [7:0] d_o
);
    logic href_q, href_p_q, vsync_q, vsync_p_q;
    logic [7:0] d_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            href_q    <= 1'b0;
            href_p_q  <= 1'b0;
            vsync_q   <= 1'b0;
            vsync_p_q <= 1'b0;
            d_q       <= '0;
        end else begin
            href_q    <= href_i == HREF_POL;
            vsync_q   <= vsync_i == VSYNC_POL;
            d_q       <= d_i;
            href_p_q  <= href_q;
            vsync_p_q <= vsync_q;
        end
    end
    assign href_o       = href_q;
    assign href_fall_o  = href_p_q & ~href_q;
    assign vsync_rise_o = vsync_q & ~vsync_p_q;
    assign d_o          = d_q;
endmodule

// File: rtl/dvp_capture.sv
// dvp_capture: assembles DVP byte pairs into cropped RGB565 words for the display FIFO write port.
// Define DVP_CAPTURE_TESTPAT_EN to add TESTPAT_SEL, which substitutes eight vertical colour bars.
module dvp_capture
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int SKIP_FRAMES = 2,
    parameter bit VSYNC_POL   = 1'b1,
    parameter bit HREF_POL    = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CAM_EN,
    dvp_capture_if.slave bus,
    input  logic         OVF_CLR,
    output logic         FRAME_START,
    output logic         FRAME_DONE,
    output logic         OVERFLOW,
    output logic [8:0]   LINE_CNT
`ifdef DVP_CAPTURE_TESTPAT_EN
    ,
    input  logic         TESTPAT_SEL
`endif
);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int SW = $clog2(SKIP_FRAMES + 2);
    logic href, href_fall, vs_rise, in_win;
    logic [7:0] d;
    logic [15:0] word;
    state_e state_q, state_d;
    logic [SW-1:0] skip_q, skip_d;
    logic [CW-1:0] col_q, col_d;
    logic [8:0] line_q, line_d;
    logic [7:0] hi_q, hi_d;
    logic [15:0] di_q, di_d;
    logic phase_q, phase_d, abort_q, abort_d, we_q, we_d;
    logic fs_q, fs_d, fd_q, fd_d, ovf_q, ovf_d;

    dvp_sync_edge #(.VSYNC_POL(VSYNC_POL), .HREF_POL(HREF_POL)) u_sync (
        .CLK(CLK),
        .RST(RST),
        .href_i(bus.CSI_HREF),
        .vsync_i(bus.CSI_VSYNC),
        .d_i(bus.CSI_D),
        .href_o(href),
        .href_fall_o(href_fall),
        .vsync_rise_o(vs_rise),
        .d_o(d)
    );

`ifdef DVP_CAPTURE_TESTPAT_EN
    assign word = TESTPAT_SEL ? bar_color(3'(32'(col_q) * 8 / H_ACTIVE)) : {hi_q, d};
`else
    assign word = {hi_q, d};
`endif
    assign in_win = 32'(col_q) < H_ACTIVE && 32'(line_q) < V_ACTIVE;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        col_d   = col_q;
        line_d  = line_q;
        hi_d    = hi_q;
        di_d    = di_q;
        phase_d = phase_q;
        we_d    = 1'b0;
        fs_d    = 1'b0;
        fd_d    = 1'b0;
        ovf_d   = ovf_q & ~OVF_CLR;
        // a line cut by VSYNC stays ignored until its HREF drops, so it never counts as a line
        abort_d = href & (abort_q | vs_rise);
        if (vs_rise) begin
            fd_d    = state_q inside {S_FRAME, S_DROP};
            line_d  = '0;
            col_d   = '0;
            phase_d = 1'b0;
            if (!CAM_EN) begin
                state_d = S_SYNC;
                skip_d  = '0;
            end else if (32'(skip_q) < SKIP_FRAMES) begin
                state_d = S_SKIP;
                skip_d  = skip_q + 1'b1;
            end else begin
                state_d = S_FRAME;
                fs_d    = 1'b1;
            end
        end else if (state_q == S_FRAME && !abort_q) begin
            if (href_fall) begin
                col_d   = '0;
                phase_d = 1'b0;
                line_d  = &line_q ? line_q : line_q + 1'b1;
            end else if (href) begin
                phase_d = ~phase_q;
                if (!phase_q) begin
                    hi_d = d;
                end else begin
                    col_d = 32'(col_q) < H_ACTIVE ? col_q + 1'b1 : col_q;
                    if (in_win) begin
                        di_d = word;
                        we_d = ~bus.FIFO_FULL;
                        if (bus.FIFO_FULL) begin
                            ovf_d   = 1'b1;
                            state_d = S_DROP;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_SYNC;
            skip_q  <= '0;
            col_q   <= '0;
            line_q  <= '0;
            hi_q    <= '0;
            di_q    <= '0;
            phase_q <= 1'b0;
            abort_q <= 1'b0;
            we_q    <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            col_q   <= col_d;
            line_q  <= line_d;
            hi_q    <= hi_d;
            di_q    <= di_d;
            phase_q <= phase_d;
            abort_q <= abort_d;
            we_q    <= we_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.FIFO_WE  = we_q;
    assign bus.FIFO_DI  = di_q;
    assign FRAME_START  = fs_q;
    assign FRAME_DONE   = fd_q;
    assign OVERFLOW     = ovf_q;
    assign LINE_CNT     = line_q;
endmodule

// File: tb/tb_dvp_capture.sv
// tb_dvp_capture: randomized scoreboard bench for dvp_capture on a reduced 16x12 window.
module tb_dvp_capture;
    localparam int H = 16;
    localparam int V = 12;
    localparam int SKIP = 2;
    logic CLK = 1'b0, RST = 1'b1, CAM_EN = 1'b0, OVF_CLR = 1'b0;
    logic FRAME_START, FRAME_DONE, OVERFLOW;
    logic [8:0] LINE_CNT;
    logic tp_sel = 1'b0;
    int checks, errors, got_fs, got_fd, exp_fs, exp_fd, settle, line_idx;
    bit cap, dropped;
    logic [15:0] got_q[$], exp_q[$];

    dvp_capture_if bus ();

    dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP)) dut (
        .CLK(CLK),
        .RST(RST),
        .CAM_EN(CAM_EN),
        .bus(bus),
        .OVF_CLR(OVF_CLR),
        .FRAME_START(FRAME_START),
        .FRAME_DONE(FRAME_DONE),
        .OVERFLOW(OVERFLOW),
        .LINE_CNT(LINE_CNT)
`ifdef DVP_CAPTURE_TESTPAT_EN
        ,
        .TESTPAT_SEL(tp_sel)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.FIFO_WE) got_q.push_back(bus.FIFO_DI);
            got_fs += int'(FRAME_START);
            got_fd += int'(FRAME_DONE);
        end
    end

    function automatic logic [15:0] bar(input int i);
        logic [15:0] c [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        return c[i];
    endfunction

    // reference: a frame is captured once SKIP enabled frames have passed since reset/enable
    task automatic model_vsync();
        if (cap) exp_fd++;
        if (!CAM_EN) begin
            settle = 0;
            cap = 1'b0;
        end else if (settle < SKIP) begin
            settle++;
            cap = 1'b0;
        end else begin
            cap = 1'b1;
            exp_fs++;
        end
        line_idx = 0;
        dropped = 1'b0;
    endtask

    task automatic vsync_pulse();
        @(negedge CLK);
        bus.FIFO_FULL = 1'b0;
        bus.CSI_VSYNC = 1'b1;
        model_vsync();
        repeat (2) @(negedge CLK);
        bus.CSI_VSYNC = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic send_line(input int nbytes, input bit fixed, input int full_at, input int vs_at);
        logic [7:0] b [$];
        int lim;
        lim = nbytes;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge CLK);
            bus.CSI_HREF = 1'b1;
            bus.CSI_D = fixed ? ((i % 2 == 0) ? 8'hF8 : 8'h00) : 8'($urandom);
            b.push_back(bus.CSI_D);
            if (i == 2 * full_at + 1) bus.FIFO_FULL = 1'b1;
            if (i == vs_at) begin
                bus.CSI_VSYNC = 1'b1;
                lim = i;
                break;
            end
        end
        for (int p = 0; 2 * p + 1 < lim; p++)
            if (cap && !dropped && line_idx < V && p < H) begin
                if (p == full_at) dropped = 1'b1;
                else exp_q.push_back(tp_sel ? bar(p * 8 / H) : {b[2*p], b[2*p+1]});
            end
        if (vs_at >= 0) begin
            model_vsync();
            repeat (2) @(negedge CLK);
            bus.CSI_VSYNC = 1'b0;
        end else begin
            @(negedge CLK);
            line_idx++;
        end
        bus.CSI_HREF = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset();
        bus.CSI_HREF = 1'b0;
        bus.CSI_VSYNC = 1'b0;
        bus.CSI_D = '0;
        bus.FIFO_FULL = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks += 6;
        if (bus.FIFO_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", bus.FIFO_WE); end
        if (bus.FIFO_DI !== 16'h0) begin errors++; $display("FAIL reset_di: got %h required 0000", bus.FIFO_DI); end
        if (FRAME_START !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b required 0", FRAME_START); end
        if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b required 0", FRAME_DONE); end
        if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", OVERFLOW); end
        if (LINE_CNT !== 9'd0) begin errors++; $display("FAIL reset_line: got %0d required 0", LINE_CNT); end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_skip();
        int n = 0;
        CAM_EN = 1'b1;
        repeat (2) begin
            vsync_pulse();
            repeat (V) send_line(2 * H, 1'b1, -1, -1);
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL skip_quiet: got %0d writes required 0", got_q.size()); end
        vsync_pulse();
        repeat (V) send_line(2 * H, 1'b1, -1, -1);
        checks += 2;
        if (got_fs != 1) begin errors++; $display("FAIL skip_fs: got %0d starts required 1", got_fs); end
        if (got_q.size() != H * V) begin errors++; $display("FAIL skip_count: got %0d writes required %0d", got_q.size(), H * V); end
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) n++;
        checks++;
        if (got_q.size() != exp_q.size() || n != 0) begin
            errors++; $display("FAIL skip_words: got %0d words (%0d wrong) required %0d", got_q.size(), n, exp_q.size());
        end
        vsync_pulse();
        checks++;
        if (got_fd != 1) begin errors++; $display("FAIL skip_fd: got %0d dones required 1", got_fd); end
    endtask

    task automatic test_long_line();
        int n = 0;
        got_q.delete();
        exp_q.delete();
        checks++;
        if (LINE_CNT !== 9'(line_idx)) begin errors++; $display("FAIL long_line0: got %0d required %0d", LINE_CNT, line_idx); end
        send_line(2 * H + 8, 1'b0, -1, -1);
        checks++;
        if (LINE_CNT !== 9'(line_idx)) begin errors++; $display("FAIL long_line1: got %0d required %0d", LINE_CNT, line_idx); end
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) n++;
        checks++;
        if (got_q.size() != H || got_q.size() != exp_q.size() || n != 0) begin
            errors++; $display("FAIL long_words: got %0d words (%0d wrong) required %0d", got_q.size(), n, H);
        end
    endtask

    task automatic test_odd_line();
        int n = 0;
        got_q.delete();
        exp_q.delete();
        send_line(7, 1'b0, -1, -1);
        send_line(2 * H, 1'b0, -1, -1);
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) n++;
        checks += 2;
        if (got_q.size() != 3 + H || got_q.size() != exp_q.size() || n != 0) begin
            errors++; $display("FAIL odd_words: got %0d words (%0d wrong) required %0d", got_q.size(), n, 3 + H);
        end
        if (LINE_CNT !== 9'(line_idx)) begin errors++; $display("FAIL odd_line: got %0d required %0d", LINE_CNT, line_idx); end
    endtask

    task automatic test_abort();
        int n = 0;
        got_q.delete();
        exp_q.delete();
        vsync_pulse();
        repeat (10) send_line(2 * H, 1'b0, -1, -1);
        send_line(2 * H, 1'b0, -1, 10);
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) n++;
        checks += 3;
        if (got_q.size() != exp_q.size() || n != 0) begin
            errors++; $display("FAIL abort_words: got %0d words (%0d wrong) required %0d", got_q.size(), n, exp_q.size());
        end
        if (LINE_CNT !== 9'd0) begin errors++; $display("FAIL abort_line: got %0d required 0", LINE_CNT); end
        if (got_fd != exp_fd) begin errors++; $display("FAIL abort_fd: got %0d dones required %0d", got_fd, exp_fd); end
    endtask

    task automatic test_overflow();
        int n = 0;
        got_q.delete();
        exp_q.delete();
        vsync_pulse();
        for (int l = 0; l < V; l++) send_line(2 * H, 1'b0, l == 5 ? 5 : -1, -1);
        checks++;
        if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", OVERFLOW); end
        vsync_pulse();
        checks++;
        if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", OVERFLOW); end
        @(negedge CLK);
        OVF_CLR = 1'b1;
        @(negedge CLK);
        OVF_CLR = 1'b0;
        @(negedge CLK);
        checks++;
        if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b required 0", OVERFLOW); end
        repeat (V) send_line(2 * H, 1'b0, -1, -1);
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) n++;
        checks++;
        if (got_q.size() != 5 * H + 5 + V * H || got_q.size() != exp_q.size() || n != 0) begin
            errors++; $display("FAIL ovf_words: got %0d words (%0d wrong) required %0d", got_q.size(), n, exp_q.size());
        end
    endtask

    task automatic test_cam_en();
        int n = 0;
        got_q.delete();
        exp_q.delete();
        vsync_pulse();
        send_line(2 * H, 1'b0, -1, -1);
        CAM_EN = 1'b0;
        send_line(2 * H, 1'b0, -1, -1);
        vsync_pulse();
        send_line(2 * H, 1'b0, -1, -1);
        checks++;
        if (got_q.size() != 2 * H) begin errors++; $display("FAIL en_finish: got %0d writes required %0d", got_q.size(), 2 * H); end
        CAM_EN = 1'b1;
        repeat (2) begin
            vsync_pulse();
            send_line(2 * H, 1'b0, -1, -1);
        end
        vsync_pulse();
        repeat (2) send_line(2 * H, 1'b0, -1, -1);
        vsync_pulse();
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) n++;
        checks += 3;
        if (got_q.size() != exp_q.size() || n != 0) begin
            errors++; $display("FAIL en_words: got %0d words (%0d wrong) required %0d", got_q.size(), n, exp_q.size());
        end
        if (got_fs != exp_fs) begin errors++; $display("FAIL en_fs: got %0d starts required %0d", got_fs, exp_fs); end
        if (got_fd != exp_fd) begin errors++; $display("FAIL en_fd: got %0d dones required %0d", got_fd, exp_fd); end
    endtask

`ifdef DVP_CAPTURE_TESTPAT_EN
    task automatic test_testpat();
        int n = 0;
        got_q.delete();
        exp_q.delete();
        tp_sel = 1'b1;
        repeat (2) send_line(2 * H, 1'b0, -1, -1);
        tp_sel = 1'b0;
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) n++;
        checks++;
        if (got_q.size() != exp_q.size() || n != 0) begin
            errors++; $display("FAIL tp_words: got %0d words (%0d wrong) required %0d", got_q.size(), n, exp_q.size());
        end
        checks++;
        if (got_q.size() < H) begin
            errors++; $display("FAIL tp_size: got %0d words required at least %0d", got_q.size(), H);
        end else begin
            checks += 3;
            if (got_q[0] !== 16'hFFFF) begin errors++; $display("FAIL tp_w0: got %h required FFFF", got_q[0]); end
            if (got_q[2] !== 16'hFFE0) begin errors++; $display("FAIL tp_w2: got %h required FFE0", got_q[2]); end
            if (got_q[H-1] !== 16'h0000) begin errors++; $display("FAIL tp_wlast: got %h required 0000", got_q[H-1]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_skip();
        test_long_line();
        test_odd_line();
        test_abort();
        test_overflow();
        test_cam_en();
`ifdef DVP_CAPTURE_TESTPAT_EN
        test_testpat();
`endif
        repeat (4) @(negedge CLK);
        checks += 2;
        if (got_fs != exp_fs) begin errors++; $display("FAIL total_fs: got %0d starts required %0d", got_fs, exp_fs); end
        if (got_fd != exp_fd) begin errors++; $display("FAIL total_fd: got %0d dones required %0d", got_fd, exp_fd); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dvp_capture.md
Name: dvp_capture

Overview:
- Camera-side writer for the display FIFO.
- Clocked by the camera pixel clock; samples the 8-bit DVP bus (CSI_D, CSI_HREF, CSI_VSYNC).
- Assembles byte pairs into RGB565 words, crops to the panel window and pushes words into the write port of the dual-clock display FIFO.
- The LCD scan-out logic drains the FIFO on the other side.

Parameters:
- H_ACTIVE, 480, pixels written per line; extra pixels are discarded.
- V_ACTIVE, 272, lines written per frame; extra lines are discarded.
- SKIP_FRAMES, 2, whole frames discarded after reset or enable, for sensor settling.
- VSYNC_POL, 1, active level of CSI_VSYNC.
- HREF_POL, 1, active level of CSI_HREF.

Ports:
- CLK  in  1  camera pixel clock (CSI_PCLK); all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- CAM_EN  in  1  capture enable; sampled only at frame boundaries
- CSI_HREF  in  1  line valid
- CSI_VSYNC  in  1  frame sync
- CSI_D  in  8  pixel byte; high byte first
- FIFO_FULL  in  1  FIFO full flag, write-clock domain
- FIFO_WE  out  1  FIFO write strobe, one cycle per word
- FIFO_DI  out  16  RGB565 word {first byte, second byte}
- FRAME_START  out  1  one-cycle pulse when a captured frame begins
- FRAME_DONE  out  1  one-cycle pulse when a captured frame ends
- OVERFLOW  out  1  sticky; set when a word is lost to FIFO_FULL
- OVF_CLR  in  1  clears OVERFLOW
- LINE_CNT  out  9  current captured line index

Behaviour:
- Reset: all outputs 0; state S_SYNC; skip counter 0; byte phase 0.
- Input stage:
  - CSI_HREF, CSI_VSYNC and CSI_D are registered once.
  - Polarity is normalised via the _POL parameters.
  - Edge detection compares the registered value with the previous registered value.
- Latency: pin to FIFO_WE is 2 CLK cycles for the second byte of a pair.
- States:
  - S_SYNC: wait for a VSYNC active edge. On it: CAM_EN=0 -> stay; skip counter < SKIP_FRAMES -> increment, go to S_SKIP; else go to S_FRAME and pulse FRAME_START.
  - S_SKIP: ignore data; the next VSYNC active edge re-evaluates as in S_SYNC.
  - S_FRAME: while HREF is active, the byte phase toggles each cycle.
    - Phase 0: latch the high byte.
    - Phase 1: if col < H_ACTIVE and LINE_CNT < V_ACTIVE, drive FIFO_DI={hi,byte}; then FIFO_FULL=0 -> FIFO_WE=1 for one cycle; FIFO_FULL=1 -> set OVERFLOW, go to S_DROP.
    - col increments per word.
  - S_DROP: no writes; on the VSYNC active edge, pulse FRAME_DONE and re-evaluate as in S_SYNC.
- HREF falling edge: col=0, phase=0; LINE_CNT increments, saturating at 511. A dangling odd byte is dropped.
- VSYNC active edge in S_FRAME:
  - Pulse FRAME_DONE and LINE_CNT=0.
  - Next state per S_SYNC rules. If it is S_FRAME, FRAME_START pulses in the same cycle.
  - VSYNC edge and HREF active in the same cycle: VSYNC wins and the line is aborted.
- Short frame (fewer than V_ACTIVE lines): no padding is written.
- OVF_CLR and an overflow event in the same cycle: set wins.
- CAM_EN falling mid-frame: the current frame completes; capture stops at the next boundary. Re-enabling restarts the skip counter at 0.
- Reset mid-frame: returns to S_SYNC, so no partial frame is ever written.

Optional Feature:
- Macro DVP_CAPTURE_TESTPAT_EN.
- Defined:
  - Adds input port TESTPAT_SEL (1 bit).
  - When TESTPAT_SEL=1, FIFO_DI is replaced by 8 vertical colour bars, bar index = col*8/H_ACTIVE.
  - Colours are white, yellow, cyan, green, magenta, red, blue, black.
  - Write timing stays driven by camera HREF/VSYNC.
- Not defined: the port is absent and FIFO_DI always carries camera data.

Decomposition:
- Package dvp_pkg:
  - state encoding (S_SYNC, S_SKIP, S_FRAME, S_DROP)
  - eight RGB565 bar colour constants
  - default 480x272 resolution constants
- Sub-module dvp_sync_edge: input register plus polarity normalisation plus rise/fall detect for HREF and VSYNC.

Test Plan:
- Reset, SKIP_FRAMES=2, three 480x272 frames with byte pairs 0xF8,0x00 -> frames 1–2 produce no FIFO_WE; frame 3 produces exactly 130560 writes of 0xF800, one FRAME_START and one FRAME_DONE.
- Line of 500 pixels (1000 bytes) -> 480 writes; LINE_CNT increments once at the HREF fall.
- FIFO_FULL forced high at word 100 of line 5 -> OVERFLOW=1, no further writes until the next VSYNC; OVF_CLR pulse clears it; the next frame captures normally.
- Line with 7 bytes -> 3 writes; 7th byte discarded; the next line starts at phase 0.
- VSYNC asserted mid-line 10 -> FRAME_DONE pulses, line aborted, LINE_CNT=0.
- DVP_CAPTURE_TESTPAT_EN with TESTPAT_SEL=1 -> word 0 =0xFFFF, word 60 =0xFFE0, word 479 =0x0000.
